timer_irq_ctrl: RTL and testbench
=================================

Name: timer_irq_ctrl

Overview:
- Memory-mapped compare/interrupt controller that sequences the free-running system timer.
- Watches the timer's 32-bit count value and raises an interrupt when the count reaches a programmed compare point, in one-shot or periodic mode.
- Provides pending/acknowledge handling and wrap-safe compare; sits on the same CPU data bus as the timer, at its own base address.

Parameters:
- RESET_PERIOD, 32'd0, reset value of the PERIOD register.
- OVF_W, 8, width of the saturating overrun counter (used only with the optional feature).

Ports:
- tirq_clk  in  1  clock, shared with the timer.
- tirq_rst  in  1  reset; synchronous, active-high.
- tirq_addr  in  32  bus address; bits [4:2] select the register.
- tirq_wen  in  1  write enable.
- tirq_raw_wdata  in  32  write data.
- tirq_rdata  out  32  read data; combinational from the registers.
- timer_value  in  32  current timer count, from the timer's value register.
- tirq_irq  out  1  interrupt request to the CPU; level, active-high.

Behaviour:
- Register map, by tirq_addr[4:2]:
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN. Read returns {29'b0, ctrl}.
  - 1 CMP: 32-bit compare point.
  - 2 PERIOD: 32-bit reload increment.
  - 3 STATUS: bit0 PENDING (write 1 to clear); bits[2:1] state encoding. Read returns {29'b0, state, pending}.
  - 4 OVERRUN: optional, see Optional Feature.
  - Any other address reads 32'hffffffff; writes to it are ignored.
- Reset (synchronous): CTRL=0, CMP=0, PERIOD=RESET_PERIOD, PENDING=0, state=IDLE, tirq_irq=0.
- Match condition: diff = timer_value - CMP (32-bit modular); match = (diff[31]==0). This is wrap-safe for compare points up to 2^31 ahead.
- States (encoding): IDLE (00), ARMED (01), FIRED (10).
  - IDLE: waits for EN=1; moves to ARMED on the edge after EN is written 1.
  - ARMED, match this edge:
    - PENDING<=1.
    - If PERIODIC=1 and PERIOD!=0: CMP<=CMP+PERIOD (modular) and stay ARMED.
    - Otherwise go to FIRED.
  - FIRED: waits for software. Writing EN=0 -> IDLE. Writing CMP returns to ARMED if EN=1.
  - Writing EN=0 in any state -> IDLE next edge; PENDING is unchanged.
- PERIOD==0 in periodic mode behaves exactly as one-shot.
- tirq_irq = PENDING & IRQ_EN, driven from registered state only. It asserts on the cycle after the matching edge: latency 1 cycle from timer_value satisfying the match.
- Simultaneous events:
  - W1C of PENDING in the same cycle as a match: the set wins, PENDING stays 1.
  - Software write to CMP in the same cycle as a periodic reload: the software value wins. The match itself still sets PENDING, evaluated against the old CMP.
  - Write to CTRL with EN=0 in the same cycle as a match: PENDING sets, state goes to IDLE, no reload.
- Reset mid-operation: all state returns to reset values on that edge and tirq_irq deasserts the next cycle.
- The compare point is never missed when timer_value jumps, e.g. when software writes the timer: any value at or past CMP (within half range) matches.

Optional Feature:
- Macro: TIRQ_OVERRUN_CNT_EN.
- Defined:
  - OVERRUN (addr idx 4) holds an OVF_W-bit counter, zero-extended on read.
  - It increments, saturating at all-ones, on every match that occurs while PENDING is already 1 (before any same-cycle clear).
  - Any write to OVERRUN clears it.
  - Reset value 0.
- Not defined: idx 4 reads 32'hffffffff; writes are ignored; no counter logic is synthesized.

Test Plan:
- Reset, then read all registers -> CTRL=0, CMP=0, PERIOD=RESET_PERIOD, STATUS=0, idx5 reads ffffffff; tirq_irq=0.
- One-shot: CMP=100, CTRL=5 (EN, IRQ_EN), ramp timer_value 90->110 -> PENDING sets on the edge where value=100; tirq_irq high next cycle; STATUS state=FIRED. Write STATUS=1 -> tirq_irq low next cycle, no re-fire.
- Periodic: CMP=10, PERIOD=10, CTRL=7, ramp value 0->45 -> matches at 10, 20, 30, 40; CMP reads 50 at end. Clear after each match -> exactly 4 interrupts.
- Wrap: CMP=32'h00000005, value ramps from 32'hfffffff0 -> no match before wrap; match at 5. Also CMP=32'hfffffff8, PERIOD=16 -> CMP reloads to 32'h00000008.
- Simultaneous: W1C of STATUS on the same edge as a periodic match -> PENDING remains 1. CMP write on a match edge -> CMP equals the written value, not CMP+PERIOD.
- With TIRQ_OVERRUN_CNT_EN: periodic PERIOD=1, never clear, 300 matches -> OVERRUN reads 255 (OVF_W=8). Write OVERRUN -> reads 0. Without the macro -> reads ffffffff.

Source files
------------

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: compare/interrupt sequencer for the free-running system timer.
// Raises a level interrupt when the timer count reaches a programmed compare
// point, in one-shot or periodic mode, using a wrap-safe compare.
// Optional build macro: TIRQ_OVERRUN_CNT_EN adds a saturating overrun counter
// at register index 4. When it is undefined, index 4 behaves as an unmapped address.
module timer_irq_ctrl #(
  parameter logic [31:0] RESET_PERIOD = 32'd0,
  parameter int          OVF_W        = 8
) (
  input  logic        tirq_clk,
  input  logic        tirq_rst,
  input  logic [31:0] tirq_addr,
  input  logic        tirq_wen,
  input  logic [31:0] tirq_raw_wdata,
  output logic [31:0] tirq_rdata,
  input  logic [31:0] timer_value,
  output logic        tirq_irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_FIRED = 2'b10
  } state_e;

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_CMP    = 3'd1;
  localparam logic [2:0] IDX_PERIOD = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_OVRN   = 3'd4;

  state_e      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;      // {IRQ_EN, PERIODIC, EN}
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] period_q, period_d;
  logic        pending_q, pending_d;

  logic [2:0]  idx;
  logic        wr_ctrl, wr_cmp, wr_period, wr_status;
  logic        disable_wr;
  logic signed [31:0] diff;
  logic        match, fire, reload;

  // Only bits [4:2] decode a register; the rest are don't-care.
  logic        unused_addr;
  assign unused_addr = ^{tirq_addr[31:5], tirq_addr[1:0]};

  assign idx        = tirq_addr[4:2];
  assign wr_ctrl    = tirq_wen && (idx == IDX_CTRL);
  assign wr_cmp     = tirq_wen && (idx == IDX_CMP);
  assign wr_period  = tirq_wen && (idx == IDX_PERIOD);
  assign wr_status  = tirq_wen && (idx == IDX_STATUS);
  assign disable_wr = wr_ctrl && !tirq_raw_wdata[0];

  // Modular difference read as signed: non-negative means the count is at or
  // past the compare point, as long as that point was less than 2^31 ahead.
  assign diff  = signed'(timer_value - cmp_q);
  assign match = (diff >= 0);
  assign fire  = (state_q == ST_ARMED) && match;
  // A reload happens only while staying armed; disabling on the match edge
  // suppresses it.
  assign reload = fire && ctrl_q[1] && (period_q != 32'd0) && !disable_wr;

  // State register.
  always_ff @(posedge tirq_clk) begin
    if (tirq_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; disabling through CTRL overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (disable_wr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (ctrl_q[0]) state_d = ST_ARMED;
        ST_ARMED: if (match && !reload) state_d = ST_FIRED;
        ST_FIRED: if (wr_cmp && ctrl_q[0]) state_d = ST_ARMED;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Register next values; a software CMP write beats the reload, and a
  // match beats a same-cycle PENDING clear.
  always_comb begin
    ctrl_d    = wr_ctrl   ? tirq_raw_wdata[2:0] : ctrl_q;
    period_d  = wr_period ? tirq_raw_wdata      : period_q;
    cmp_d     = cmp_q;
    if (wr_cmp)      cmp_d = tirq_raw_wdata;
    else if (reload) cmp_d = cmp_q + period_q;
    pending_d = pending_q;
    if (fire)                               pending_d = 1'b1;
    else if (wr_status && tirq_raw_wdata[0]) pending_d = 1'b0;
  end

  // Register file update.
  always_ff @(posedge tirq_clk) begin
    if (tirq_rst) begin
      ctrl_q    <= 3'b000;
      cmp_q     <= 32'd0;
      period_q  <= RESET_PERIOD;
      pending_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      cmp_q     <= cmp_d;
      period_q  <= period_d;
      pending_q <= pending_d;
    end
  end

  assign tirq_irq = pending_q & ctrl_q[2];

`ifdef TIRQ_OVERRUN_CNT_EN
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic             wr_ovf;

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign wr_ovf = tirq_wen && (idx == IDX_OVRN);

  // Count matches that land while an interrupt is still unserviced.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_ovf)                 ovf_d = '0;
    else if (fire && pending_q) ovf_d = sat_inc(ovf_q);
  end

  // Overrun counter register.
  always_ff @(posedge tirq_clk) begin
    if (tirq_rst) ovf_q <= '0;
    else          ovf_q <= ovf_d;
  end
`else
  logic [OVF_W-1:0] unused_ovf_w;
  assign unused_ovf_w = '0;
`endif

  // Combinational read mux.
  always_comb begin
    tirq_rdata = 32'hffff_ffff;
    case (idx)
      IDX_CTRL:   tirq_rdata = {29'b0, ctrl_q};
      IDX_CMP:    tirq_rdata = cmp_q;
      IDX_PERIOD: tirq_rdata = period_q;
      IDX_STATUS: tirq_rdata = {29'b0, state_q, pending_q};
`ifdef TIRQ_OVERRUN_CNT_EN
      IDX_OVRN:   tirq_rdata = 32'(ovf_q);
`endif
      default:    tirq_rdata = 32'hffff_ffff;
    endcase
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed testbench for timer_irq_ctrl: reset values, one-shot, periodic,
// wrap-around, simultaneous events, timer jumps, mid-run reset and the
// optional overrun counter (TIRQ_OVERRUN_CNT_EN).
module tb_timer_irq_ctrl;

  localparam logic [31:0] RST_PER = 32'h0000_1234;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] tval;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  timer_irq_ctrl #(
    .RESET_PERIOD(RST_PER),
    .OVF_W       (8)
  ) dut (
    .tirq_clk      (clk),
    .tirq_rst      (rst),
    .tirq_addr     (addr),
    .tirq_wen      (wen),
    .tirq_raw_wdata(wdata),
    .tirq_rdata    (rdata),
    .timer_value   (tval),
    .tirq_irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    addr  = {27'b0, idx, 2'b00};
    wdata = d;
    wen   = 1'b1;
    @(posedge clk);
    #1;
    wen   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, output logic [31:0] d);
    addr = {27'b0, idx, 2'b00};
    #1;
    d = rdata;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          irq_cnt;

    rst = 1'b1; addr = '0; wen = 1'b0; wdata = '0; tval = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rd(3'd0, d); chk("rst_ctrl", d, 32'd0);
    rd(3'd1, d); chk("rst_cmp", d, 32'd0);
    rd(3'd2, d); chk("rst_period", d, RST_PER);
    rd(3'd3, d); chk("rst_status", d, 32'd0);
    rd(3'd5, d); chk("rst_idx5", d, 32'hffff_ffff);
    rd(3'd7, d); chk("rst_idx7", d, 32'hffff_ffff);

    // One-shot: CMP=100, ramp 90..110
    tval = 32'd90;
    wr(3'd1, 32'd100);
    wr(3'd0, 32'd5);
    rd(3'd0, d); chk("os_ctrl", d, 32'd5);
    for (int v = 90; v <= 110; v++) begin
      tval = v;
      tick();
      if (v >= 98 && v <= 101) chk($sformatf("os_irq_v%0d", v), {31'b0, irq}, (v >= 100) ? 32'd1 : 32'd0);
    end
    rd(3'd3, d); chk("os_status_fired", d, 32'd5);
    wr(3'd3, 32'd1);
    chk("os_irq_cleared", {31'b0, irq}, 32'd0);
    tick(); tick();
    chk("os_no_refire", {31'b0, irq}, 32'd0);
    rd(3'd3, d); chk("os_status_after_clr", d, 32'd4);
    wr(3'd0, 32'd0);
    rd(3'd3, d); chk("os_disable_idle", d, 32'd0);

    // Periodic: CMP=10, PERIOD=10, ramp 0..45, clear after each interrupt
    tval = 32'd0;
    wr(3'd1, 32'd10);
    wr(3'd2, 32'd10);
    wr(3'd0, 32'd7);
    irq_cnt = 0;
    for (int v = 0; v <= 45; v++) begin
      tval = v;
      tick();
      if (irq) begin
        irq_cnt++;
        wr(3'd3, 32'd1);
        chk($sformatf("per_clr_v%0d", v), {31'b0, irq}, 32'd0);
      end
    end
    chk("per_irq_count", irq_cnt, 32'd4);
    rd(3'd1, d); chk("per_cmp_end", d, 32'd50);
    rd(3'd3, d); chk("per_status_armed", d, 32'd2);
    wr(3'd0, 32'd0);

    // Wrap: CMP=5, timer from fffffff0 across zero
    tval = 32'hffff_fff0;
    wr(3'd1, 32'd5);
    wr(3'd0, 32'd5);
    for (int i = 0; i <= 21; i++) begin
      tval = 32'hffff_fff0 + 32'(i);
      tick();
      if (i == 0 || i == 15 || i == 16 || i == 20 || i == 21)
        chk($sformatf("wrap_irq_i%0d", i), {31'b0, irq}, (i == 21) ? 32'd1 : 32'd0);
    end
    rd(3'd3, d); chk("wrap_status", d, 32'd5);
    wr(3'd3, 32'd1);
    wr(3'd0, 32'd0);

    // Wrap reload: CMP=fffffff8 + PERIOD 16 -> 8
    tval = 32'hffff_fff0;
    wr(3'd1, 32'hffff_fff8);
    wr(3'd2, 32'd16);
    wr(3'd0, 32'd7);
    tick();
    tval = 32'hffff_fff8;
    tick();
    chk("wrapre_irq", {31'b0, irq}, 32'd1);
    rd(3'd1, d); chk("wrapre_cmp", d, 32'h0000_0008);
    wr(3'd3, 32'd1);
    wr(3'd0, 32'd0);

    // Simultaneous: W1C on a periodic match edge
    tval = 32'd0;
    wr(3'd1, 32'd10);
    wr(3'd2, 32'd10);
    wr(3'd0, 32'd7);
    tick();
    tval = 32'd10;
    wr(3'd3, 32'd1);
    rd(3'd3, d); chk("sim_w1c_pending", d, 32'd3);
    chk("sim_w1c_irq", {31'b0, irq}, 32'd1);
    rd(3'd1, d); chk("sim_w1c_cmp", d, 32'd20);
    // CMP write on a match edge: software value wins
    tval = 32'd20;
    wr(3'd1, 32'd100);
    rd(3'd1, d); chk("sim_cmpwr_cmp", d, 32'd100);
    rd(3'd3, d); chk("sim_cmpwr_status", d, 32'd3);
    // CTRL EN=0 on a match edge: pending set, idle, no reload
    wr(3'd3, 32'd1);
    rd(3'd3, d); chk("sim_pre_dis_status", d, 32'd2);
    tval = 32'd100;
    wr(3'd0, 32'd6);
    rd(3'd3, d); chk("sim_dis_status", d, 32'd1);
    rd(3'd1, d); chk("sim_dis_cmp", d, 32'd100);
    chk("sim_dis_irq", {31'b0, irq}, 32'd1);
    tick();
    rd(3'd1, d); chk("sim_dis_cmp_hold", d, 32'd100);

    // Timer jump past CMP, IRQ_EN masking, FIRED -> ARMED by CMP write
    wr(3'd3, 32'd1);
    tval = 32'd0;
    wr(3'd1, 32'd1000);
    wr(3'd0, 32'd1);
    tick();
    tval = 32'd5000;
    tick();
    rd(3'd3, d); chk("jump_status", d, 32'd5);
    chk("jump_irq_masked", {31'b0, irq}, 32'd0);
    wr(3'd0, 32'd5);
    chk("jump_irq_unmasked", {31'b0, irq}, 32'd1);
    wr(3'd1, 32'd6000);
    rd(3'd3, d); chk("jump_rearm_status", d, 32'd3);

    // Write to an unmapped address is ignored
    wr(3'd5, 32'd0);
    rd(3'd0, d); chk("unmapped_wr_ctrl", d, 32'd5);
    rd(3'd1, d); chk("unmapped_wr_cmp", d, 32'd6000);

    // Reset mid-operation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_irq", {31'b0, irq}, 32'd0);
    rd(3'd3, d); chk("midrst_status", d, 32'd0);
    rd(3'd0, d); chk("midrst_ctrl", d, 32'd0);
    rd(3'd1, d); chk("midrst_cmp", d, 32'd0);
    rd(3'd2, d); chk("midrst_period", d, RST_PER);

`ifdef TIRQ_OVERRUN_CNT_EN
    // Overrun counter saturates at 255 with 300 uncleared matches
    tval = 32'd0;
    rd(3'd4, d); chk("ovf_rst", d, 32'd0);
    wr(3'd1, 32'd1);
    wr(3'd2, 32'd1);
    wr(3'd0, 32'd3);
    tick();
    for (int v = 1; v <= 300; v++) begin
      tval = v;
      tick();
      if (v == 3) begin
        rd(3'd4, d); chk("ovf_early", d, 32'd2);
      end
    end
    rd(3'd4, d); chk("ovf_sat", d, 32'd255);
    wr(3'd4, 32'd0);
    rd(3'd4, d); chk("ovf_clr", d, 32'd0);
`else
    rd(3'd4, d); chk("idx4_unmapped", d, 32'hffff_ffff);
    wr(3'd4, 32'd7);
    rd(3'd4, d); chk("idx4_after_wr", d, 32'hffff_ffff);
    rd(3'd0, d); chk("idx4_wr_ctrl", d, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
